des_unpack: RTL and testbench

DES_UNPACK -- requirements
Module: des_unpack

---
 rtl/des_unpack.sv | 90 +++++++++
 tb/tb_des_unpack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_unpack.sv
// des_unpack: credit-gated result FIFO that serialises 64-bit DES blocks to bytes.
// Define DES_UNPACK_LAST_EN to add the olast end-of-block marker output.
module des_unpack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  output logic        credit,
  input  logic [63:0] od,
  input  logic        outvalid,
  output logic [7:0]  odata,
  output logic        ovalid,
  input  logic        oready,
`ifdef DES_UNPACK_LAST_EN
  output logic        olast,
`endif
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [2:0]    bidx;
  logic [CW:0]   used;
  logic [63:0]   head;
  logic          iss_ok;
  logic          ov_ok;
  logic          take;
  logic          pop;
  logic          wr;
  logic          bad;

  always_comb begin
    used   = {1'b0, inflight} + {1'b0, count};
    credit = used < LIM;
    ovalid = count != '0;
    head   = mem[rptr];
    // ~bidx == 7-bidx: byte 0 is the most significant byte
    odata  = ovalid ? 8'(head >> {~bidx, 3'b000}) : 8'h00;
    take   = ovalid && oready;
    pop    = take && (bidx == 3'd7);
    iss_ok = issue && credit;
    ov_ok  = outvalid && (inflight != '0);
    // a pop in the same cycle frees the slot the write needs
    wr     = ov_ok && ((count != FULL) || pop);
    bad    = (issue && !credit)
          || (outvalid && (inflight == '0))
          || (ov_ok && !wr);
  end

`ifdef DES_UNPACK_LAST_EN
  assign olast = ovalid && (bidx == 3'd7);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      bidx     <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= inflight + CW'(iss_ok) - CW'(ov_ok);
      count    <= count + CW'(wr) - CW'(pop);
      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (take)
        bidx <= bidx + 3'd1;
      if (bad)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= od;
  end

endmodule

// File: tb/tb_des_unpack.sv
// tb_des_unpack: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_des_unpack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue = 1'b0;
  logic        outvalid = 1'b0;
  logic        oready = 1'b0;
  logic [63:0] od = '0;
  logic        credit;
  logic        ovalid;
  logic        err;
  logic [7:0]  odata;
`ifdef DES_UNPACK_LAST_EN
  logic        olast;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  des_unpack #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .issue(issue),
    .credit(credit),
    .od(od),
    .outvalid(outvalid),
    .odata(odata),
    .ovalid(ovalid),
    .oready(oready),
`ifdef DES_UNPACK_LAST_EN
    .olast(olast),
`endif
    .err(err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: blocks in a queue, byte index, outstanding count
  logic [63:0] q[$];
  int          m_inf = 0;
  int          m_idx = 0;
  bit          m_err = 0;
  bit          m_cr;
  bit          m_ov;
  bit          m_ok;
  logic [7:0]  got[$];

  function automatic logic [7:0] exp_byte();
    if (q.size() == 0) return 8'h00;
    return 8'(q[0] >> (8 * (7 - m_idx)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_inf = 0;
      m_idx = 0;
      m_err = 0;
    end else begin
      m_cr = (m_inf + q.size()) < DEPTH;
      m_ov = q.size() != 0;
      m_ok = outvalid && (m_inf > 0);
      if (issue && !m_cr) m_err = 1;
      if (outvalid && m_inf == 0) m_err = 1;
      if (m_ov && oready) begin
        if (m_idx == 7) begin
          void'(q.pop_front());
          m_idx = 0;
        end else m_idx++;
      end
      if (m_ok) begin
        if (q.size() < DEPTH) q.push_back(od);
        else m_err = 1;
      end
      if (issue && m_cr) m_inf++;
      if (m_ok) m_inf--;
    end
  end

  logic       hold = 1'b0;
  logic [7:0] held = '0;

  always @(negedge clk) begin
    chk("ovalid", ovalid, q.size() != 0);
    chk("odata", odata, exp_byte());
    chk("credit", credit, (m_inf + q.size()) < DEPTH);
    chk("err", err, m_err);
`ifdef DES_UNPACK_LAST_EN
    chk("olast", olast, (q.size() != 0) && (m_idx == 7));
`endif
    if (hold && ovalid) chk("stall_hold", odata, held);
    hold = ovalid && !oready;
    held = odata;
    if (ovalid && oready) got.push_back(odata);
  end

  task automatic cyc(input logic i, input logic v,
                     input logic [63:0] d, input logic r);
    issue = i;
    outvalid = v;
    od = d;
    oready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc(1'b0, 1'b0, 64'h0, r);
  endtask

  task automatic do_reset();
    issue = 1'b0;
    outvalid = 1'b0;
    oready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [63:0] kb  = 64'h85E813540F0AB405;
  logic [63:0] b6  = 64'h0123456789ABCDEF;
  logic [63:0] b7  = 64'hA1A2A3A4A5A6A7A8;
  logic [63:0] b8  = 64'hC3D4E5F60718293A;
  logic [7:0]  kv[8] = '{8'h85, 8'hE8, 8'h13, 8'h54,
                         8'h0F, 8'h0A, 8'hB4, 8'h05};

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_credit", credit, 1'b1);
    chk("rst_ovalid", ovalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_odata", odata, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // single block with known bytes
    got.delete();
    cyc(1'b1, 1'b0, 64'h0, 1'b1);
    idle(16, 1'b1);
    cyc(1'b0, 1'b1, kb, 1'b1);
    chk("lat_valid", ovalid, 1'b1);
    chk("lat_byte0", odata, 8'h85);
    idle(10, 1'b1);
    chk("blk_nbytes", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("blk_byte%0d", i), got[i], kv[i]);
    chk("blk_err", err, 1'b0);

    // credit limit with a stalled sink
    repeat (4) cyc(1'b1, 1'b0, 64'h0, 1'b0);
    chk("cred_zero", credit, 1'b0);
    cyc(1'b0, 1'b1, 64'h1111111111111111, 1'b0);
    cyc(1'b0, 1'b1, 64'h2222222222222222, 1'b0);
    cyc(1'b0, 1'b1, 64'h3333333333333333, 1'b0);
    cyc(1'b0, 1'b1, 64'h4444444444444444, 1'b0);
    chk("full_err", err, 1'b0);
    chk("full_credit", credit, 1'b0);
    idle(8, 1'b1);
    chk("drain1_credit", credit, 1'b1);

    // write coincides with the byte-7 pop
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    chk("sim_credit", credit, 1'b0);
    idle(7, 1'b1);
    cyc(1'b0, 1'b1, 64'h5555555555555555, 1'b1);
    chk("sim_err", err, 1'b0);
    chk("sim_next", odata, 8'h33);
    idle(40, 1'b1);
    chk("sim_empty", ovalid, 1'b0);

    // backpressure pattern 1,0,0
    got.delete();
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 1'b1, b6, 1'b0);
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b0, 64'h0, (i % 3) == 0);
    chk("bp_nbytes", got.size(), 8);
    chk("bp_first", got.size() > 0 ? got[0] : 8'hxx, 8'h01);
    chk("bp_last", got.size() > 7 ? got[7] : 8'hxx, 8'hEF);
    chk("bp_empty", ovalid, 1'b0);

    // issue without credit, then stray outvalid after reset
    repeat (4) cyc(1'b1, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    chk("viol_err", err, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 64'h6666666666666666, 1'b0);
    idle(8, 1'b1);
    chk("viol_inflight", credit, 1'b1);
    do_reset();
    cyc(1'b0, 1'b1, 64'h7777777777777777, 1'b0);
    chk("stray_err", err, 1'b1);
    chk("stray_count", ovalid, 1'b0);

    // reset in the middle of a block
    do_reset();
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b1, b7, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("mid_byte3", odata, 8'hA4);
    rst = 1'b1;
    #1;
    chk("mid_ovalid", ovalid, 1'b0);
    chk("mid_credit", credit, 1'b1);
    chk("mid_err", err, 1'b0);
    chk("mid_odata", odata, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b1, b8, 1'b0);
    chk("post_byte0", odata, 8'hC3);
    idle(10, 1'b1);
    chk("post_nbytes", got.size(), 8);
    chk("post_first", got.size() > 0 ? got[0] : 8'hxx, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
